serial_borrow_subtractor: RTL and testbench

Multi-cycle two's-complement subtractor, D = A - B, for the 15-bit adder/subtractor datapath. It is the subtract-direction counterpart of the 3-bit carry-lookahead adder slice. It resolves one DIGIT-bit slice per clock using borrow-lookahead inside the slice and a registered ripple borrow between slices. It reports an unsigned borrow-out and signed overflow, with a valid/ready handshake on both the operand side and the result side.

---
 rtl/serial_borrow_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_borrow_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle two's-complement subtractor D = A - B, resolving DIGIT bits per clock
// with borrow-lookahead inside the slice and a registered borrow between slices.
module serial_borrow_subtractor #(
    parameter int WIDTH = 15,
    parameter int DIGIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  aq_reg;
    logic [WIDTH-1:0]  bq_reg;
    logic              borrow_reg;
    logic [CW-1:0]     cnt_reg;

    logic [DIGIT-1:0]  a_sl;
    logic [DIGIT-1:0]  b_sl;
    logic [DIGIT-1:0]  g_sl;
    logic [DIGIT-1:0]  p_sl;
    logic [DIGIT-1:0]  d_sl;
    logic [DIGIT:0]    bc;

    assign start_ready = (state_reg == IDLE) & ~rst;
    assign res_valid   = (state_reg == DONE);

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_reg == CW'(k)) begin
                a_sl = aq_reg[k*DIGIT +: DIGIT];
                b_sl = bq_reg[k*DIGIT +: DIGIT];
            end
        end
    end

    assign g_sl  = ~a_sl & b_sl;
    assign p_sl  = ~(a_sl ^ b_sl);
    assign bc[0] = borrow_reg;

    // Each borrow is a flat sum of products of g/p and the slice borrow-in,
    // so no borrow depends on the one below it within the cycle.
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
            logic pp;
            logic acc;
            always_comb begin
                pp  = 1'b1;
                acc = 1'b0;
                for (int k = gi; k >= 0; k--) begin
                    acc = acc | (pp & g_sl[k]);
                    pp  = pp & p_sl[k];
                end
                acc = acc | (pp & borrow_reg);
            end
            assign bc[gi+1] = acc;
        end
    endgenerate

    assign d_sl = a_sl ^ b_sl ^ bc[DIGIT-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            aq_reg     <= '0;
            bq_reg     <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            D          <= '0;
            Bout       <= 1'b0;
            V          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        aq_reg     <= A;
                        bq_reg     <= B;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (cnt_reg == CW'(k)) begin
                            D[k*DIGIT +: DIGIT] <= d_sl;
                        end
                    end
                    borrow_reg <= bc[DIGIT];
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        // The top slice holds the sign bit of the new difference.
                        Bout      <= bc[DIGIT];
                        V         <= (aq_reg[WIDTH-1] ^ bq_reg[WIDTH-1]) &
                                     (d_sl[DIGIT-1] ^ aq_reg[WIDTH-1]);
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor: expected {D,Bout,V} are queued
// at accept time and popped when res_valid appears.
module tb_serial_borrow_subtractor;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [14:0] A;
    logic [14:0] B;
    logic        res_valid;
    logic        res_ready;
    logic [14:0] D;
    logic        Bout;
    logic        V;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] exp_q[$];

    serial_borrow_subtractor dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .A(A), .B(B),
        .res_valid(res_valid), .res_ready(res_ready),
        .D(D), .Bout(Bout), .V(V)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [14:0] a, input logic [14:0] b);
        logic [14:0] d;
        logic        bo;
        logic        v;
        d  = a - b;
        bo = (a < b);
        v  = (a[14] != b[14]) && (d[14] != a[14]);
        return {d, bo, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [14:0] a, input logic [14:0] b, input bit release_res);
        int cycles;
        logic [16:0] e;
        logic [16:0] got;
        start_valid = 1'b1;
        A = a;
        B = b;
        n_checks++;
        if (start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL op_start_ready a=%h b=%h got=%b want=1", a, b, start_ready);
        end
        exp_q.push_back(model(a, b));
        step();
        start_valid = 1'b0;
        A = 15'($urandom);
        B = 15'($urandom);
        cycles = 0;
        while (res_valid !== 1'b1 && cycles < 20) begin
            step();
            cycles++;
        end
        n_checks++;
        if (cycles !== 5) begin
            n_fail++;
            $display("FAIL op_latency a=%h b=%h got=%0d want=5", a, b, cycles);
        end
        e   = exp_q.pop_front();
        got = {D, Bout, V};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL op_result a=%h b=%h got D=%h Bout=%b V=%b want D=%h Bout=%b V=%b",
                     a, b, got[16:2], got[1], got[0], e[16:2], e[1], e[0]);
        end
        $display("op a=%h b=%h -> D=%h Bout=%b V=%b", a, b, D, Bout, V);
        if (release_res) begin
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            n_checks++;
            if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL op_release got res_valid=%b start_ready=%b want 0/1", res_valid, start_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b1;
        res_ready = 1'b0;
        A = 15'h1111;
        B = 15'h0222;
        step();
        step();
        n_checks++;
        if (res_valid !== 1'b0 || D !== 15'h0 || Bout !== 1'b0 || V !== 1'b0 || start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got rv=%b D=%h Bout=%b V=%b sr=%b want 0 0 0 0 0",
                     res_valid, D, Bout, V, start_ready);
        end
        start_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got=%b want=1", start_ready);
        end
        $display("reset checked");
    endtask

    task automatic test_directed();
        run_op(15'h0000, 15'h0001, 1);
        run_op(15'h3FFF, 15'h7FFF, 1);
        run_op(15'h4000, 15'h0001, 1);
        run_op(15'h1555, 15'h1555, 1);
        run_op(15'h0123, 15'h4000, 1);
    endtask

    task automatic test_backpressure();
        run_op(15'd100, 15'd58, 0);
        start_valid = 1'b1;
        A = 15'd7;
        B = 15'd2;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (res_valid !== 1'b1 || D !== 15'h002A || start_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold cyc=%0d got rv=%b D=%h sr=%b want 1 002a 0",
                         i, res_valid, D, start_ready);
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release got sr=%b rv=%b want 1 0", start_ready, res_valid);
        end
        $display("backpressure hold done");
        run_op(15'd7, 15'd2, 1);
    endtask

    task automatic test_reset_mid_op();
        start_valid = 1'b1;
        A = 15'h1234;
        B = 15'h0100;
        step();
        start_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (D !== 15'h0 || res_valid !== 1'b0 || start_ready !== 1'b0 || Bout !== 1'b0 || V !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset got D=%h rv=%b sr=%b Bout=%b V=%b want 0 0 0 0 0",
                     D, res_valid, start_ready, Bout, V);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_ready got=%b want=1", start_ready);
        end
        $display("mid-op reset checked");
        run_op(15'd5, 15'd3, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            run_op(15'($urandom), 15'($urandom), 1);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_directed();
        test_reset_mid_op();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty got=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
